chrono_counter: RTL and testbench
=================================

Name: chrono_counter

Overview:
- Stopwatch time base, directly downstream of the clock divider.
- Consumes the divider's 1-cycle 100 Hz pulse as `tick` and accumulates elapsed time as packed BCD MM:SS.cc.
- Start/stop, lap and clear commands arrive as single-cycle pulses from the button conditioning stage. `disp` feeds the 7-segment driver.

Parameters:
- MIN_MAX, 59, highest minute value before wrap; legal range 1..99.

Ports:
- clk_in  input  1  system clock; same clock the divider runs on.
- rst_n  input  1  asynchronous, active-low reset.
- tick  input  1  one-cycle pulse at 100 Hz (divider output); each pulse is one centisecond.
- start_stop  input  1  one-cycle command pulse: toggle run/pause.
- lap  input  1  one-cycle command pulse: freeze/unfreeze display while counting.
- clear  input  1  one-cycle command pulse: zero the count (only when stopped).
- disp  output  24  {min_t, min_u, sec_t, sec_u, cs_t, cs_u}, 4-bit BCD each, MSB first.
- running  output  1  1 in RUN or LAP.
- lap_active  output  1  1 in LAP.
- ovf  output  1  sticky; set on wrap past MIN_MAX:59.99.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, internal count 0, lap snapshot 0, disp 0x000000, running 0, lap_active 0, ovf 0. Reset mid-run discards everything; no command or tick is remembered.
- All outputs are registered.
- State machine: IDLE, RUN, PAUSE, LAP. Transitions are evaluated on the registered state.
- IDLE:
  - start_stop -> RUN.
  - lap and clear are ignored.
- RUN:
  - start_stop -> PAUSE.
  - lap -> LAP; the snapshot captures the count value including any tick in that same cycle.
  - clear is ignored.
- LAP:
  - lap -> RUN; the display tracks the live count again.
  - start_stop -> PAUSE; the display shows the live count.
  - clear is ignored.
- PAUSE:
  - start_stop -> RUN.
  - clear -> IDLE; count, snapshot and ovf are zeroed.
  - lap is ignored.
- Simultaneous commands: priority is clear > start_stop > lap, applied only where the command is legal in the current state.
  - PAUSE with clear and start_stop together -> IDLE.
  - RUN with start_stop and lap together -> PAUSE.
- Count enable = (state is RUN or LAP) before any transition in that cycle.
  - A tick in the same cycle as start_stop leaving IDLE/PAUSE is not counted.
  - A tick in the same cycle as start_stop leaving RUN/LAP is counted.
- Latency: disp reflects a tick one clk_in cycle after the tick is sampled. Commands take effect on state/outputs one cycle after being sampled.
- Increment: BCD ripple, all in one cycle.
  - cs_u 9->0 carries into cs_t; cs 99->00 carries into sec_u.
  - sec_u 9->0 carries into sec_t; sec 59->00 carries into minutes.
  - Minutes are a BCD pair counting 00..MIN_MAX.
- Wrap: tick at MIN_MAX:59.99 -> 00:00.00, ovf <= 1, counting continues. ovf clears only on reset or clear.
- disp source:
  - Live count in IDLE, RUN, PAUSE.
  - Lap snapshot in LAP.
- Digits never hold non-BCD values. Minute tens never exceed the tens digit of MIN_MAX.
- tick held high for N cycles counts N centiseconds; no edge detection. Upstream guarantees single-cycle pulses.

Test Plan:
- Reset, start_stop, 150 ticks -> disp 0x000150, running 1, ovf 0.
- start_stop, 37 ticks, start_stop, 20 ticks -> disp 0x000037, running 0. Then start_stop, 5 ticks -> 0x000042.
- Run 5999 ticks -> 0x005999; one more tick -> 0x010000.
- MIN_MAX=1: run 11999 ticks -> 0x015999; next tick -> 0x000000, ovf 1. Then start_stop, clear -> ovf 0, IDLE.
- Lap path: 250 ticks, lap, 100 ticks -> disp 0x000250, lap_active 1. Then lap -> disp 0x000350, lap_active 0.
- Command corners:
  - clear in RUN is ignored.
  - clear+start_stop in PAUSE -> IDLE, disp 0x000000.
  - start_stop coincident with tick from IDLE -> tick not counted.
  - rst_n low mid-run, asynchronously -> all outputs 0 immediately.

Source files
------------

// File: rtl/chrono_counter.sv
`default_nettype none
// ============================================================================
// Module      : chrono_counter
// Description : Stopwatch time base. Accumulates 100 Hz tick pulses as packed
//               BCD MM:SS.cc and handles run/pause, lap freeze and clear
//               commands. Every output is registered.
// Ports       :
//   clk_in      - system clock (the same clock the divider runs on)
//   rst_n       - asynchronous active-low reset
//   tick        - one-cycle 100 Hz pulse; each pulse is one centisecond
//   start_stop  - command pulse: toggle run/pause
//   lap         - command pulse: freeze/unfreeze the display while counting
//   clear       - command pulse: zero the count (honoured only when paused)
//   disp        - {min_t, min_u, sec_t, sec_u, cs_t, cs_u}, BCD, MSB first
//   running     - 1 in RUN or LAP
//   lap_active  - 1 in LAP
//   ovf         - sticky flag, set when the count wraps past MIN_MAX:59.99
// Revision    : 1.0 - initial release
// ============================================================================
module chrono_counter #(
    parameter int MIN_MAX = 59
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    output logic [23:0] disp,
    output logic        running,
    output logic        lap_active,
    output logic        ovf
);

    localparam logic [3:0] C_MIN_T = 4'(MIN_MAX / 10);
    localparam logic [3:0] C_MIN_U = 4'(MIN_MAX % 10);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LAP   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [23:0] r_count;
    logic [23:0] r_snap;
    logic [23:0] w_count_inc;
    logic [23:0] w_count_nxt;
    logic [23:0] w_snap_nxt;
    logic        w_ovf_nxt;
    logic        w_cnt_en;
    logic        w_wrap;
    logic [3:0]  w_mt, w_mu, w_st, w_su, w_ct, w_cu;

    // Counting follows the state held at the start of the cycle, so a tick
    // coincident with a start/stop command is judged by the old state.
    assign w_cnt_en = tick && ((r_state == S_RUN) || (r_state == S_LAP));

    // One-cycle BCD ripple increment of the whole MM:SS.cc value.
    always_comb begin
        {w_mt, w_mu, w_st, w_su, w_ct, w_cu} = r_count;
        w_wrap = 1'b0;
        if (w_cu != 4'd9) begin
            w_cu = w_cu + 4'd1;
        end else begin
            w_cu = 4'd0;
            if (w_ct != 4'd9) begin
                w_ct = w_ct + 4'd1;
            end else begin
                w_ct = 4'd0;
                if (w_su != 4'd9) begin
                    w_su = w_su + 4'd1;
                end else begin
                    w_su = 4'd0;
                    if (w_st != 4'd5) begin
                        w_st = w_st + 4'd1;
                    end else begin
                        w_st = 4'd0;
                        if ((w_mt == C_MIN_T) && (w_mu == C_MIN_U)) begin
                            w_mt   = 4'd0;
                            w_mu   = 4'd0;
                            w_wrap = 1'b1;
                        end else if (w_mu == 4'd9) begin
                            w_mu = 4'd0;
                            w_mt = w_mt + 4'd1;
                        end else begin
                            w_mu = w_mu + 4'd1;
                        end
                    end
                end
            end
        end
        w_count_inc = {w_mt, w_mu, w_st, w_su, w_ct, w_cu};
    end

    // Next-state and datapath update. Command priority is clear >
    // start_stop > lap, applied only where the command is legal.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = w_cnt_en ? w_count_inc : r_count;
        w_snap_nxt  = r_snap;
        w_ovf_nxt   = ovf | (w_cnt_en & w_wrap);
        case (r_state)
            S_IDLE: begin
                if (start_stop) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (start_stop) begin
                    w_state_nxt = S_PAUSE;
                end else if (lap) begin
                    w_state_nxt = S_LAP;
                    // Snapshot includes a tick arriving in this same cycle.
                    w_snap_nxt  = w_count_nxt;
                end
            end
            S_LAP: begin
                if (start_stop) begin
                    w_state_nxt = S_PAUSE;
                end else if (lap) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_PAUSE: begin
                if (clear) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = 24'h000000;
                    w_snap_nxt  = 24'h000000;
                    w_ovf_nxt   = 1'b0;
                end else if (start_stop) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_count    <= 24'h000000;
            r_snap     <= 24'h000000;
            disp       <= 24'h000000;
            running    <= 1'b0;
            lap_active <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_snap     <= w_snap_nxt;
            ovf        <= w_ovf_nxt;
            // Outputs are built from next-state values so they line up
            // with the state register one cycle after the sampled input.
            disp       <= (w_state_nxt == S_LAP) ? w_snap_nxt : w_count_nxt;
            running    <= (w_state_nxt == S_RUN) || (w_state_nxt == S_LAP);
            lap_active <= (w_state_nxt == S_LAP);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chrono_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_chrono_counter
// Description : Directed self-checking bench for chrono_counter. Two
//               instances share stimulus: one with the default MIN_MAX of 59
//               and one with MIN_MAX=1 for the wrap/overflow path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chrono_counter;

    logic        clk_in;
    logic        rst_n;
    logic        tick;
    logic        start_stop;
    logic        lap;
    logic        clear;
    logic [23:0] disp;
    logic        running;
    logic        lap_active;
    logic        ovf;
    logic [23:0] disp1;
    logic        running1;
    logic        lap_active1;
    logic        ovf1;

    int total;
    int bad;

    chrono_counter #(.MIN_MAX(59)) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .tick       (tick),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .disp       (disp),
        .running    (running),
        .lap_active (lap_active),
        .ovf        (ovf)
    );

    chrono_counter #(.MIN_MAX(1)) dut1 (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .tick       (tick),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .disp       (disp1),
        .running    (running1),
        .lap_active (lap_active1),
        .ovf        (ovf1)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Apply one cycle of inputs; returns 1 time unit after the sampling edge.
    task automatic drive(input logic t, input logic ss, input logic lp, input logic cl);
        tick       = t;
        start_stop = ss;
        lap        = lp;
        clear      = cl;
        @(posedge clk_in);
        #1;
        tick       = 1'b0;
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #4;
        rst_n = 1'b1;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset;
        do_reset();
        total++; if (disp !== 24'h000000) begin bad++; $display("FAIL reset_disp got=%h exp=%h", disp, 24'h000000); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b exp=0", running); end
        total++; if (lap_active !== 1'b0) begin bad++; $display("FAIL reset_lap_active got=%b exp=0", lap_active); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    endtask

    task automatic test_basic_run;
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(150);
        total++; if (disp !== 24'h000150) begin bad++; $display("FAIL run150_disp got=%h exp=%h", disp, 24'h000150); end
        total++; if (running !== 1'b1) begin bad++; $display("FAIL run150_running got=%b exp=1", running); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL run150_ovf got=%b exp=0", ovf); end
    endtask

    task automatic test_pause_resume;
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(37);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(20);
        total++; if (disp !== 24'h000037) begin bad++; $display("FAIL pause_disp got=%h exp=%h", disp, 24'h000037); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL pause_running got=%b exp=0", running); end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(5);
        total++; if (disp !== 24'h000042) begin bad++; $display("FAIL resume_disp got=%h exp=%h", disp, 24'h000042); end
    endtask

    task automatic test_minute_carry;
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(5999);
        total++; if (disp !== 24'h005999) begin bad++; $display("FAIL carry5999_disp got=%h exp=%h", disp, 24'h005999); end
        ticks(1);
        total++; if (disp !== 24'h010000) begin bad++; $display("FAIL carry_min_disp got=%h exp=%h", disp, 24'h010000); end
    endtask

    task automatic test_wrap;
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(11999);
        total++; if (disp1 !== 24'h015999) begin bad++; $display("FAIL wrap_pre_disp got=%h exp=%h", disp1, 24'h015999); end
        total++; if (ovf1 !== 1'b0) begin bad++; $display("FAIL wrap_pre_ovf got=%b exp=0", ovf1); end
        ticks(1);
        total++; if (disp1 !== 24'h000000) begin bad++; $display("FAIL wrap_disp got=%h exp=%h", disp1, 24'h000000); end
        total++; if (ovf1 !== 1'b1) begin bad++; $display("FAIL wrap_ovf got=%b exp=1", ovf1); end
        total++; if (disp !== 24'h020000) begin bad++; $display("FAIL m59_2min_disp got=%h exp=%h", disp, 24'h020000); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL m59_ovf got=%b exp=0", ovf); end
        ticks(3);
        total++; if (disp1 !== 24'h000003) begin bad++; $display("FAIL wrap_continue got=%h exp=%h", disp1, 24'h000003); end
        total++; if (ovf1 !== 1'b1) begin bad++; $display("FAIL wrap_sticky got=%b exp=1", ovf1); end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (ovf1 !== 1'b0) begin bad++; $display("FAIL clear_ovf got=%b exp=0", ovf1); end
        total++; if (disp1 !== 24'h000000) begin bad++; $display("FAIL clear_disp got=%h exp=%h", disp1, 24'h000000); end
        total++; if (running1 !== 1'b0) begin bad++; $display("FAIL clear_running got=%b exp=0", running1); end
        // IDLE: lap and ticks do nothing.
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        total++; if (lap_active1 !== 1'b0) begin bad++; $display("FAIL idle_lap_active got=%b exp=0", lap_active1); end
        total++; if (disp1 !== 24'h000000) begin bad++; $display("FAIL idle_tick_disp got=%h exp=%h", disp1, 24'h000000); end
    endtask

    task automatic test_lap;
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(250);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(100);
        total++; if (disp !== 24'h000250) begin bad++; $display("FAIL lap_frozen_disp got=%h exp=%h", disp, 24'h000250); end
        total++; if (lap_active !== 1'b1) begin bad++; $display("FAIL lap_active_on got=%b exp=1", lap_active); end
        total++; if (running !== 1'b1) begin bad++; $display("FAIL lap_running got=%b exp=1", running); end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        total++; if (disp !== 24'h000350) begin bad++; $display("FAIL lap_release_disp got=%h exp=%h", disp, 24'h000350); end
        total++; if (lap_active !== 1'b0) begin bad++; $display("FAIL lap_active_off got=%b exp=0", lap_active); end
        // Lap with a coincident tick: the snapshot includes that tick.
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        ticks(3);
        total++; if (disp !== 24'h000351) begin bad++; $display("FAIL lap_tick_snap got=%h exp=%h", disp, 24'h000351); end
        // start_stop with tick while in LAP: tick counted, live count shown.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        total++; if (disp !== 24'h000355) begin bad++; $display("FAIL lap_stop_disp got=%h exp=%h", disp, 24'h000355); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL lap_stop_running got=%b exp=0", running); end
        total++; if (lap_active !== 1'b0) begin bad++; $display("FAIL lap_stop_lap_active got=%b exp=0", lap_active); end
    endtask

    task automatic test_corners;
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(10);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (running !== 1'b1) begin bad++; $display("FAIL run_clear_running got=%b exp=1", running); end
        total++; if (disp !== 24'h000010) begin bad++; $display("FAIL run_clear_disp got=%h exp=%h", disp, 24'h000010); end
        ticks(2);
        total++; if (disp !== 24'h000012) begin bad++; $display("FAIL run_clear_cont got=%h exp=%h", disp, 24'h000012); end
        // Pause, then lap in PAUSE is ignored and ticks are not counted.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        total++; if (lap_active !== 1'b0) begin bad++; $display("FAIL pause_lap got=%b exp=0", lap_active); end
        total++; if (disp !== 24'h000012) begin bad++; $display("FAIL pause_tick got=%h exp=%h", disp, 24'h000012); end
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        total++; if (disp !== 24'h000000) begin bad++; $display("FAIL clr_ss_disp got=%h exp=%h", disp, 24'h000000); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL clr_ss_running got=%b exp=0", running); end
        // start_stop with tick from IDLE: tick not counted.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        total++; if (disp !== 24'h000000) begin bad++; $display("FAIL idle_ss_tick got=%h exp=%h", disp, 24'h000000); end
        total++; if (running !== 1'b1) begin bad++; $display("FAIL idle_ss_running got=%b exp=1", running); end
        ticks(1);
        total++; if (disp !== 24'h000001) begin bad++; $display("FAIL first_tick got=%h exp=%h", disp, 24'h000001); end
        // RUN with start_stop and lap together: PAUSE wins.
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        total++; if (running !== 1'b0) begin bad++; $display("FAIL ss_lap_running got=%b exp=0", running); end
        total++; if (lap_active !== 1'b0) begin bad++; $display("FAIL ss_lap_lap_active got=%b exp=0", lap_active); end
        // Asynchronous reset mid-run, checked before any clock edge.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(5);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        total++; if (disp !== 24'h000000) begin bad++; $display("FAIL async_disp got=%h exp=%h", disp, 24'h000000); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL async_running got=%b exp=0", running); end
        total++; if (lap_active !== 1'b0) begin bad++; $display("FAIL async_lap_active got=%b exp=0", lap_active); end
        total++; if (ovf1 !== 1'b0) begin bad++; $display("FAIL async_ovf got=%b exp=0", ovf1); end
        #2;
        rst_n = 1'b1;
        @(posedge clk_in);
        #1;
        ticks(4);
        total++; if (disp !== 24'h000000) begin bad++; $display("FAIL post_reset_idle got=%h exp=%h", disp, 24'h000000); end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        tick       = 1'b0;
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
        @(posedge clk_in);
        #1;
        test_reset();
        test_basic_run();
        test_pause_resume();
        test_minute_carry();
        test_wrap();
        test_lap();
        test_corners();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
